// File: rtl/enc_width_up_converter.sv
// rtl/enc_width_up_converter.sv - packs Ratio narrow source beats into one wide output word
module enc_width_up_converter #(
  parameter int InputDataWidth = 16,
  parameter int Ratio          = 2,
  parameter bit FirstLaneMsb   = 1'b1,
  localparam int OutputDataWidth = InputDataWidth * Ratio,
  localparam int LaneCountWidth  = $clog2(Ratio) + 1
) (
  input  logic                       iClock,
  input  logic                       iReset,
  input  logic                       iSrcDataValid,
  input  logic                       iSrcDataLast,
  input  logic                       iSrcParityLast,
  input  logic [InputDataWidth-1:0]  iSrcData,
  output logic                       oConverterReady,
  output logic                       oConvertedDataValid,
  output logic                       oConvertedDataLast,
  output logic                       oConvertedParityLast,
  output logic [OutputDataWidth-1:0] oConvertedData,
  output logic [LaneCountWidth-1:0]  oConvertedLaneCount,
  input  logic                       iDstReady
);

  localparam int LaneIdxWidth = $clog2(Ratio);

  // Lanes 0..Ratio-2 are buffered; the final lane always comes straight from iSrcData.
  logic [InputDataWidth-1:0]  acc [Ratio-1];
  logic [LaneIdxWidth-1:0]    lane;
  logic                       parity_flag;
  logic                       accept;
  logic                       complete;
  logic [OutputDataWidth-1:0] word;

  // Bit offset of lane k inside the output word.
  function automatic int lane_shift(input int k);
    return FirstLaneMsb ? (Ratio - 1 - k) * InputDataWidth : k * InputDataWidth;
  endfunction

  // Ready depends only on the registered output stage and the sink, never on the source.
  assign oConverterReady = !oConvertedDataValid || iDstReady;
  assign accept          = iSrcDataValid && oConverterReady;
  assign complete        = accept && ((lane == LaneIdxWidth'(Ratio - 1)) || iSrcDataLast);

  // Assemble the outgoing word: populated lanes from the accumulator, current beat, zeros elsewhere.
  always_comb begin
    word = '0;
    for (int k = 0; k < Ratio - 1; k++) begin
      if (k < int'(lane)) begin
        word = word | (OutputDataWidth'(acc[k]) << lane_shift(k));
      end
    end
    word = word | (OutputDataWidth'(iSrcData) << lane_shift(int'(lane)));
  end

  // Accumulator, lane counter and sticky parity-last flag.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      lane        <= '0;
      parity_flag <= 1'b0;
      for (int k = 0; k < Ratio - 1; k++) begin
        acc[k] <= '0;
      end
    end else if (accept) begin
      if (complete) begin
        lane        <= '0;
        parity_flag <= 1'b0;
      end else begin
        lane <= lane + LaneIdxWidth'(1);
        if (iSrcParityLast) begin
          parity_flag <= 1'b1;
        end
        for (int k = 0; k < Ratio - 1; k++) begin
          if (int'(lane) == k) begin
            acc[k] <= iSrcData;
          end
        end
      end
    end
  end

  // Output stage: load on a completing beat, drop valid after transfer, otherwise hold.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      oConvertedDataValid  <= 1'b0;
      oConvertedDataLast   <= 1'b0;
      oConvertedParityLast <= 1'b0;
      oConvertedData       <= '0;
      oConvertedLaneCount  <= '0;
    end else if (complete) begin
      oConvertedDataValid  <= 1'b1;
      oConvertedDataLast   <= iSrcDataLast;
      oConvertedParityLast <= parity_flag || iSrcParityLast;
      oConvertedData       <= word;
      oConvertedLaneCount  <= LaneCountWidth'(lane) + LaneCountWidth'(1);
    end else if (oConvertedDataValid && iDstReady) begin
      oConvertedDataValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_enc_width_up_converter.sv
// tb/tb_enc_width_up_converter.sv - scoreboard bench for enc_width_up_converter
module tb_enc_width_up_converter;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        plast;
    logic [3:0]  cnt;
    logic [1:0]  dut;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  s_valid = '0;
  logic [2:0]  s_last = '0;
  logic [2:0]  s_plast = '0;
  logic [2:0]  d_ready = 3'b111;
  logic [15:0] s_data [3];

  wire  [2:0]  rdy;
  wire  [2:0]  o_valid;
  wire  [2:0]  o_last;
  wire  [2:0]  o_plast;
  wire  [31:0] d0_data;
  wire  [63:0] d1_data;
  wire  [31:0] d2_data;
  wire  [1:0]  d0_cnt;
  wire  [2:0]  d1_cnt;
  wire  [1:0]  d2_cnt;
  wire  [63:0] o_data [3];
  wire  [3:0]  o_cnt [3];

  assign o_data[0] = {32'h0, d0_data};
  assign o_data[1] = d1_data;
  assign o_data[2] = {32'h0, d2_data};
  assign o_cnt[0]  = {2'b0, d0_cnt};
  assign o_cnt[1]  = {1'b0, d1_cnt};
  assign o_cnt[2]  = {2'b0, d2_cnt};

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   accepted2 = 0;
  int   ratio [3] = '{2, 4, 2};
  bit   msb [3]   = '{1'b1, 1'b1, 1'b0};
  int   mlane [3];
  bit   mpar [3];
  logic [15:0] mbeats [3][8];
  exp_t sb [$];

  always #5 clk = ~clk;

  enc_width_up_converter #(.InputDataWidth(16), .Ratio(2), .FirstLaneMsb(1'b1)) u_r2_msb (
    .iClock(clk), .iReset(rst_n), .iSrcDataValid(s_valid[0]), .iSrcDataLast(s_last[0]),
    .iSrcParityLast(s_plast[0]), .iSrcData(s_data[0]), .oConverterReady(rdy[0]),
    .oConvertedDataValid(o_valid[0]), .oConvertedDataLast(o_last[0]),
    .oConvertedParityLast(o_plast[0]), .oConvertedData(d0_data),
    .oConvertedLaneCount(d0_cnt), .iDstReady(d_ready[0]));

  enc_width_up_converter #(.InputDataWidth(16), .Ratio(4), .FirstLaneMsb(1'b1)) u_r4_msb (
    .iClock(clk), .iReset(rst_n), .iSrcDataValid(s_valid[1]), .iSrcDataLast(s_last[1]),
    .iSrcParityLast(s_plast[1]), .iSrcData(s_data[1]), .oConverterReady(rdy[1]),
    .oConvertedDataValid(o_valid[1]), .oConvertedDataLast(o_last[1]),
    .oConvertedParityLast(o_plast[1]), .oConvertedData(d1_data),
    .oConvertedLaneCount(d1_cnt), .iDstReady(d_ready[1]));

  enc_width_up_converter #(.InputDataWidth(16), .Ratio(2), .FirstLaneMsb(1'b0)) u_r2_lsb (
    .iClock(clk), .iReset(rst_n), .iSrcDataValid(s_valid[2]), .iSrcDataLast(s_last[2]),
    .iSrcParityLast(s_plast[2]), .iSrcData(s_data[2]), .oConverterReady(rdy[2]),
    .oConvertedDataValid(o_valid[2]), .oConvertedDataLast(o_last[2]),
    .oConvertedParityLast(o_plast[2]), .oConvertedData(d2_data),
    .oConvertedLaneCount(d2_cnt), .iDstReady(d_ready[2]));

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference packing: beat k goes to its lane, lanes past the last beat stay zero.
  task automatic model_accept(input int d);
    exp_t e;
    int   sh;
    mbeats[d][mlane[d]] = s_data[d];
    if (s_plast[d]) mpar[d] = 1'b1;
    if (d == 2) accepted2++;
    if (mlane[d] == ratio[d] - 1 || s_last[d]) begin
      e = '0;
      for (int k = 0; k <= mlane[d]; k++) begin
        sh = msb[d] ? (ratio[d] - 1 - k) * 16 : k * 16;
        e.data = e.data | (64'(mbeats[d][k]) << sh);
      end
      e.last  = s_last[d];
      e.plast = mpar[d];
      e.cnt   = 4'(mlane[d] + 1);
      e.dut   = 2'(d);
      sb.push_back(e);
      mlane[d] = 0;
      mpar[d]  = 1'b0;
    end else begin
      mlane[d]++;
    end
  endtask

  task automatic check_pop(input int d);
    int idx;
    exp_t e;
    idx = -1;
    for (int i = 0; i < sb.size(); i++) begin
      if (idx < 0 && sb[i].dut == 2'(d)) idx = i;
    end
    if (idx < 0) begin
      chk($sformatf("unexpected_word_dut%0d", d), 72'(o_data[d]), 72'h0);
      if (o_data[d] == 64'h0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_word_dut%0d: observed word with empty scoreboard, expected none", d);
      end
    end else begin
      e = sb[idx];
      sb.delete(idx);
      chk($sformatf("word_dut%0d", d), {2'b0, o_data[d], o_last[d], o_plast[d], o_cnt[d]},
          {2'b0, e.data, e.last, e.plast, e.cnt});
    end
  endtask

  // One clock: sample at the falling edge, then return 1ns after the rising edge.
  task automatic cycle();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (o_valid[d] && d_ready[d]) check_pop(d);
      if (s_valid[d] && rdy[d]) model_accept(d);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic beat(input int d, input logic [15:0] data, input logic last, input logic plast);
    s_valid[d] = 1'b1;
    s_data[d]  = data;
    s_last[d]  = last;
    s_plast[d] = plast;
    cycle();
    s_valid[d] = 1'b0;
    s_last[d]  = 1'b0;
    s_plast[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      s_data[d] = '0;
      mlane[d]  = 0;
      mpar[d]   = 1'b0;
    end

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_valid", 72'(o_valid), 72'h0);
    chk("rst_ready", 72'(rdy), 72'h7);
    chk("rst_data1", 72'(o_data[1]), 72'h0);
    chk("rst_cnt0", 72'(o_cnt[0]), 72'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 72'(rdy), 72'h7);
    cycle();

    // Two beats back to back, MSB-first
    beat(0, 16'hAAAA, 1'b0, 1'b0);
    beat(0, 16'hBBBB, 1'b0, 1'b0);
    chk("pair_valid", 72'(o_valid[0]), 72'h1);
    chk("pair_data", 72'(o_data[0]), 72'hAAAABBBB);
    chk("pair_cnt", 72'(o_cnt[0]), 72'h2);
    chk("pair_last", 72'(o_last[0]), 72'h0);
    cycle();

    // Partial word on frame last, Ratio 4
    beat(1, 16'h0001, 1'b0, 1'b0);
    beat(1, 16'h0002, 1'b0, 1'b0);
    beat(1, 16'h0003, 1'b1, 1'b0);
    chk("partial_data", 72'(o_data[1]), 72'h0001_0002_0003_0000);
    chk("partial_cnt", 72'(o_cnt[1]), 72'h3);
    chk("partial_last", 72'(o_last[1]), 72'h1);
    cycle();

    // Backpressure: word held while the sink stalls, source beat waits
    d_ready[0] = 1'b0;
    beat(0, 16'h1111, 1'b0, 1'b0);
    beat(0, 16'h2222, 1'b0, 1'b0);
    s_valid[0] = 1'b1;
    s_data[0]  = 16'h3333;
    for (int i = 0; i < 5; i++) begin
      chk("hold_ready", 72'(rdy[0]), 72'h0);
      chk("hold_data", 72'(o_data[0]), 72'h11112222);
      chk("hold_valid", 72'(o_valid[0]), 72'h1);
      cycle();
    end
    d_ready[0] = 1'b1;
    #1;
    chk("release_ready", 72'(rdy[0]), 72'h1);
    cycle();
    beat(0, 16'h4444, 1'b0, 1'b0);
    chk("after_hold_data", 72'(o_data[0]), 72'h33334444);
    cycle();

    // Parity-last marks only the word carrying it
    beat(0, 16'h5555, 1'b0, 1'b1);
    beat(0, 16'h6666, 1'b0, 1'b0);
    chk("parity_word", 72'(o_plast[0]), 72'h1);
    beat(0, 16'h7777, 1'b0, 1'b0);
    beat(0, 16'h8888, 1'b0, 1'b0);
    chk("parity_next", 72'(o_plast[0]), 72'h0);
    cycle();
    cycle();

    // Reset mid-word discards the partial accumulation
    beat(1, 16'h0009, 1'b0, 1'b0);
    beat(1, 16'h000A, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 72'(o_valid), 72'h0);
    for (int d = 0; d < 3; d++) begin
      mlane[d] = 0;
      mpar[d]  = 1'b0;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    beat(1, 16'h0005, 1'b0, 1'b0);
    beat(1, 16'h0006, 1'b0, 1'b0);
    beat(1, 16'h0007, 1'b0, 1'b0);
    beat(1, 16'h0008, 1'b0, 1'b0);
    chk("post_rst_data", 72'(o_data[1]), 72'h0005_0006_0007_0008);
    chk("post_rst_cnt", 72'(o_cnt[1]), 72'h4);
    cycle();

    // Random traffic, LSB-first, random valid/ready
    while (accepted2 < 1000 && cyc < 20000) begin
      s_valid[2] = ($urandom_range(0, 3) != 0);
      s_data[2]  = 16'($urandom);
      s_last[2]  = ($urandom_range(0, 4) == 0);
      s_plast[2] = ($urandom_range(0, 6) == 0);
      d_ready[2] = ($urandom_range(0, 2) != 0);
      cycle();
    end
    chk("random_beats", 72'(accepted2), 72'd1000);
    s_valid[2] = 1'b0;
    d_ready[2] = 1'b1;
    cycle();
    cycle();
    cycle();
    chk("scoreboard_empty", 72'(sb.size()), 72'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
